// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, baud divisor table and
// FSM state encoding, common to uart_byte_rx and uart_byte_tx.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned OVERSAMPLE = 16;

   // Tick-within-bit counter values; the counter holds (tick number - 1),
   // so ticks 5..11 of a bit are values 4..10 and tick 16 is value 15.
   localparam logic [3:0] SAMPLE_FIRST_IDX = 4'd4;
   localparam logic [3:0] SAMPLE_LAST_IDX  = 4'd10;
   localparam logic [3:0] BIT_LAST_IDX     = 4'd15;
   localparam logic [2:0] VOTE_MIN         = 3'd4;

   localparam int unsigned BAUD_9600   = 9_600;
   localparam int unsigned BAUD_19200  = 19_200;
   localparam int unsigned BAUD_38400  = 38_400;
   localparam int unsigned BAUD_57600  = 57_600;
   localparam int unsigned BAUD_115200 = 115_200;

   function automatic int unsigned baud_rate(input logic [2:0] sel);
      case (sel)
         3'd0:    return BAUD_9600;
         3'd1:    return BAUD_19200;
         3'd2:    return BAUD_38400;
         3'd3:    return BAUD_57600;
         default: return BAUD_115200;
      endcase
   endfunction

   // Clocks per oversample tick, rounded to nearest.
   function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                                input logic [2:0]  sel);
      int unsigned rate;
      rate = baud_rate(sel);
      return (clk_freq + (OVERSAMPLE * rate) / 2) / (OVERSAMPLE * rate);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; counter is held at zero while disabled so
// the first tick of a frame lands one full divisor after enable.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [2:0] baud_sel,
   output logic       tick
);

   localparam int unsigned MAX_DIV = baud_divisor(CLK_FREQ, 3'd0);
   localparam int unsigned CNT_W   = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DIV_M1 [8] = '{
      cnt_t'(baud_divisor(CLK_FREQ, 3'd0) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd1) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd2) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd3) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd4) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd5) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd6) - 1),
      cnt_t'(baud_divisor(CLK_FREQ, 3'd7) - 1)
   };

   cnt_t cnt_q, cnt_d;
   logic at_end;

   assign at_end = (cnt_q == DIV_M1[baud_sel]);
   assign tick   = en && at_end;

   // NOTE: assign a default before any branch so no path leaves cnt_d
   // unassigned, which would infer a latch.
   always_comb begin
      cnt_d = '0;
      if (en && !at_end) begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1, 16x oversampled, 7-sample majority vote per bit,
// frame ends mid-stop-bit so back-to-back frames are caught.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   input  logic [2:0] baud_set,
   output logic [7:0] data_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       uart_state
);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        hist_q, hist_d;
   uart_state_e state_q, state_d;
   logic [2:0]  baud_sel_q, baud_sel_d;
   logic [3:0]  ticks_q, ticks_d;
   logic [2:0]  ones_q, ones_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_byte_q, data_byte_d;
   logic        rx_done_q, rx_done_d;
   logic        frame_err_q, frame_err_d;
   logic        uart_state_q, uart_state_d;

   logic       tick;
   logic       fall_edge;
   logic       sample_tick;
   logic       vote_tick;
   logic       bit_end;
   logic [2:0] ones_sum;
   logic       bit_val;

   uart_baud_tick #(
      .CLK_FREQ(CLK_FREQ)
   ) u_baud_tick (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (uart_state_q),
      .baud_sel (baud_sel_q),
      .tick     (tick)
   );

   assign fall_edge   = hist_q && !sync2_q;
   assign sample_tick = tick && (ticks_q >= SAMPLE_FIRST_IDX) && (ticks_q <= SAMPLE_LAST_IDX);
   assign vote_tick   = tick && (ticks_q == SAMPLE_LAST_IDX);
   assign bit_end     = tick && (ticks_q == BIT_LAST_IDX);
   // The vote includes the sample taken on the deciding tick itself.
   assign ones_sum    = ones_q + {2'b00, sync2_q};
   assign bit_val     = (ones_sum >= VOTE_MIN);

   always_comb begin
      sync1_d      = uart_rx;
      sync2_d      = sync1_q;
      hist_d       = sync2_q;
      state_d      = state_q;
      baud_sel_d   = baud_sel_q;
      ticks_d      = ticks_q;
      ones_d       = ones_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_byte_d  = data_byte_q;
      rx_done_d    = 1'b0;
      frame_err_d  = 1'b0;
      uart_state_d = uart_state_q;

      if (tick) begin
         ticks_d = ticks_q + 4'd1;
      end
      if (sample_tick) begin
         ones_d = ones_sum;
      end
      if (vote_tick) begin
         ones_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            ticks_d = '0;
            ones_d  = '0;
            if (fall_edge) begin
               state_d      = ST_START;
               uart_state_d = 1'b1;
               baud_sel_d   = baud_set;
               bit_idx_d    = '0;
            end
         end
         ST_START: begin
            // A start bit that votes high was a glitch on an idle line.
            if (vote_tick && bit_val) begin
               state_d      = ST_IDLE;
               uart_state_d = 1'b0;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (vote_tick) begin
               shift_d = {bit_val, shift_q[7:1]};
            end
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (vote_tick) begin
               state_d      = ST_IDLE;
               uart_state_d = 1'b0;
               if (bit_val) begin
                  data_byte_d = shift_q;
                  rx_done_d   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d      = ST_IDLE;
            uart_state_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         hist_q       <= 1'b1;
         state_q      <= ST_IDLE;
         baud_sel_q   <= '0;
         ticks_q      <= '0;
         ones_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_byte_q  <= '0;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         uart_state_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         hist_q       <= hist_d;
         state_q      <= state_d;
         baud_sel_q   <= baud_sel_d;
         ticks_q      <= ticks_d;
         ones_q       <= ones_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_byte_q  <= data_byte_d;
         rx_done_q    <= rx_done_d;
         frame_err_q  <= frame_err_d;
         uart_state_q <= uart_state_d;
      end
   end

   assign data_byte  = data_byte_q;
   assign rx_done    = rx_done_q;
   assign frame_err  = frame_err_q;
   assign uart_state = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: one instance at 50 MHz for single-frame corner
// cases, one at 8 MHz so slow baud rates and streams stay short.
module tb_uart_byte_rx;

   localparam int CLK_A = 50_000_000;
   localparam int CLK_B = 8_000_000;
   localparam int DIV_A [8] = '{326, 163, 81, 54, 27, 27, 27, 27};
   localparam int DIV_B [8] = '{52, 26, 13, 9, 4, 4, 4, 4};

   logic       clk = 1'b0;
   logic       reset_n;
   logic       uart_rx;
   logic [2:0] baud_set;

   logic [7:0] data_byte_a, data_byte_b;
   logic       rx_done_a, rx_done_b;
   logic       frame_err_a, frame_err_b;
   logic       uart_state_a, uart_state_b;

   uart_byte_rx #(.CLK_FREQ(CLK_A)) dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .uart_rx    (uart_rx),
      .baud_set   (baud_set),
      .data_byte  (data_byte_a),
      .rx_done    (rx_done_a),
      .frame_err  (frame_err_a),
      .uart_state (uart_state_a)
   );

   uart_byte_rx #(.CLK_FREQ(CLK_B)) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .uart_rx    (uart_rx),
      .baud_set   (baud_set),
      .data_byte  (data_byte_b),
      .rx_done    (rx_done_b),
      .frame_err  (frame_err_b),
      .uart_state (uart_state_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_a = 0, err_a = 0, done_b = 0, err_b = 0, both_high = 0;
   int done_cyc_a   = 0;
   int tx_start_cyc = 0;
   logic [7:0] rx_q_b [$];
   int         done_cyc_q_b [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done_a) begin
         done_a++;
         done_cyc_a = cyc;
      end
      if (frame_err_a) err_a++;
      if (rx_done_b) begin
         done_b++;
         rx_q_b.push_back(data_byte_b);
         done_cyc_q_b.push_back(cyc);
      end
      if (frame_err_b) err_b++;
      if ((rx_done_a && frame_err_a) || (rx_done_b && frame_err_b)) both_high++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one 8N1 frame, each bit exactly bit_clks cycles, changing on negedges.
   task automatic send_byte(input int bit_clks, input logic [7:0] b, input logic stop_val);
      logic [9:0] frame;
      frame = {stop_val, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = frame[i];
         if (i == 0) tx_start_cyc = cyc;
         repeat (bit_clks - 1) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] byte_at(input int idx);
      if (idx < rx_q_b.size()) return 32'(rx_q_b[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] cyc_at(input int idx);
      if (idx < done_cyc_q_b.size()) return 32'(done_cyc_q_b[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   typedef struct {
      logic [2:0] baud;
      logic [7:0] data;
      logic       stop;
      int         exp_done;
      int         exp_err;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_200_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, e0, bit_a, bit_b;
      logic [7:0] exp_b;

      vecs[0] = '{3'd4, 8'h55, 1'b1, 1, 0, 8'h55};
      vecs[1] = '{3'd1, 8'h3C, 1'b1, 1, 0, 8'h3C};
      vecs[2] = '{3'd2, 8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{3'd3, 8'h00, 1'b1, 1, 0, 8'h00};
      vecs[4] = '{3'd5, 8'h81, 1'b0, 0, 1, 8'h00};
      vecs[5] = '{3'd6, 8'h6E, 1'b1, 1, 0, 8'h6E};
      vecs[6] = '{3'd7, 8'h01, 1'b1, 1, 0, 8'h01};
      vecs[7] = '{3'd3, 8'h80, 1'b0, 0, 1, 8'h01};

      reset_n  = 1'b0;
      uart_rx  = 1'b1;
      baud_set = 3'd4;
      repeat (5) @(negedge clk);
      check("reset_data_a",  data_byte_a,  0);
      check("reset_done_a",  rx_done_a,    0);
      check("reset_err_a",   frame_err_a,  0);
      check("reset_state_a", uart_state_a, 0);
      check("reset_data_b",  data_byte_b,  0);
      check("reset_done_b",  rx_done_b,    0);
      check("reset_err_b",   frame_err_b,  0);
      check("reset_state_b", uart_state_b, 0);
      reset_n = 1'b1;
      idle(20);

      // 50 MHz, 115200: single good frame with exact start-to-done latency.
      bit_a = 16 * DIV_A[4];
      d0 = done_a; e0 = err_a;
      send_byte(bit_a, 8'h55, 1'b1);
      idle(2 * bit_a);
      check("b4_0x55_done",    done_a - d0, 1);
      check("b4_0x55_err",     err_a - e0, 0);
      check("b4_0x55_byte",    data_byte_a, 8'h55);
      check("b4_0x55_state",   uart_state_a, 0);
      check("b4_0x55_latency", done_cyc_a - tx_start_cyc, 3 + 155 * DIV_A[4]);

      // 2 us (100 clocks) low glitch.
      d0 = done_a; e0 = err_a;
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      check("glitch_busy", uart_state_a, 1);
      repeat (49) @(negedge clk);
      idle(2 * bit_a);
      check("glitch_done",  done_a - d0, 0);
      check("glitch_err",   err_a - e0, 0);
      check("glitch_state", uart_state_a, 0);

      // Stop bit driven low.
      d0 = done_a; e0 = err_a;
      send_byte(bit_a, 8'h81, 1'b0);
      idle(2 * bit_a);
      check("stop_low_done", done_a - d0, 0);
      check("stop_low_err",  err_a - e0, 1);
      check("stop_low_byte", data_byte_a, 8'h55);

      // Reset during data bit 3, then a clean frame.
      d0 = done_a; e0 = err_a;
      fork
         send_byte(bit_a, 8'hF8, 1'b1);
         begin
            repeat (1900) @(negedge clk);
            check("rst_pre_busy", uart_state_a, 1);
            reset_n = 1'b0;
            repeat (10) @(negedge clk);
            check("rst_mid_data",  data_byte_a,  0);
            check("rst_mid_done",  rx_done_a,    0);
            check("rst_mid_err",   frame_err_a,  0);
            check("rst_mid_state", uart_state_a, 0);
            reset_n = 1'b1;
         end
      join
      idle(2 * bit_a);
      check("rst_abort_done", done_a - d0, 0);
      check("rst_abort_err",  err_a - e0, 0);
      d0 = done_a;
      send_byte(bit_a, 8'hC3, 1'b1);
      idle(2 * bit_a);
      check("rst_after_done", done_a - d0, 1);
      check("rst_after_err",  err_a - e0, 0);
      check("rst_after_byte", data_byte_a, 8'hC3);
      idle(2000);

      // 8 MHz instance: table of single frames across baud selections.
      for (int i = 0; i < 8; i++) begin
         baud_set = vecs[i].baud;
         bit_b = 16 * DIV_B[vecs[i].baud];
         d0 = done_b; e0 = err_b;
         send_byte(bit_b, vecs[i].data, vecs[i].stop);
         idle(2 * bit_b);
         check($sformatf("vec%0d_done", i),  done_b - d0, vecs[i].exp_done);
         check($sformatf("vec%0d_err", i),   err_b - e0, vecs[i].exp_err);
         check($sformatf("vec%0d_byte", i),  data_byte_b, vecs[i].exp_byte);
         check($sformatf("vec%0d_state", i), uart_state_b, 0);
      end

      // baud_set changed mid-frame must not disturb the frame in flight.
      baud_set = 3'd4;
      d0 = done_b;
      fork
         send_byte(16 * DIV_B[4], 8'h5A, 1'b1);
         begin
            repeat (10) @(negedge clk);
            baud_set = 3'd0;
         end
      join
      idle(2 * 16 * DIV_B[4]);
      check("latch_done", done_b - d0, 1);
      check("latch_byte", data_byte_b, 8'h5A);

      // 9600 back-to-back, no idle gap between frames.
      baud_set = 3'd0;
      bit_b = 16 * DIV_B[0];
      rx_q_b.delete();
      done_cyc_q_b.delete();
      e0 = err_b;
      send_byte(bit_b, 8'hA5, 1'b1);
      send_byte(bit_b, 8'h3C, 1'b1);
      idle(bit_b);
      check("b2b_count",    rx_q_b.size(), 2);
      check("b2b_first",    byte_at(0), 8'hA5);
      check("b2b_second",   byte_at(1), 8'h3C);
      check("b2b_interval", cyc_at(1) - cyc_at(0), 10 * bit_b);
      check("b2b_err",      err_b - e0, 0);

      // Back-to-back stream at the fastest rate.
      baud_set = 3'd7;
      bit_b = 16 * DIV_B[7];
      rx_q_b.delete();
      e0 = err_b;
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'(i * 37 + 11);
         send_byte(bit_b, exp_b, 1'b1);
      end
      idle(2 * bit_b);
      check("stream_count", rx_q_b.size(), 16);
      check("stream_err",   err_b - e0, 0);
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'(i * 37 + 11);
         check($sformatf("stream_byte%0d", i), byte_at(i), exp_b);
      end

      check("done_err_exclusive", both_high, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
